// File: rtl/control_unit.sv
`timescale 1ns / 100ps
// control_unit
// Multicycle MIPS control: a Moore main FSM that sequences each instruction
// through fetch/decode/execute/memory/writeback, plus a combinational ALU
// decoder. The two are linked by an internal 2-bit alu_op.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset (forces FETCH)
//   Opcode     instruction bits [31:26]
//   Funct      instruction bits [5:0]
//   MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite, PCWrite,
//   Branch, RegWrite   datapath selects / enables (state-only)
//   ALUSrcB    B-operand select: 00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   ALUControl 010 add, 110 sub, 000 and, 001 or, 111 slt
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       IorD,
    output logic       PCSrc,
    output logic       ALUSrcA,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegWrite,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= next_state;
    end

    // Next-state logic: the only place Opcode is consulted.
    always_comb begin
        next_state = FETCH;
        unique case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEXEC;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (Opcode == OP_LW)      next_state = MEMREAD;
                else if (Opcode == OP_SW) next_state = MEMWRITE;
                else                      next_state = FETCH;
            end
            MEMREAD:  next_state = MEMWB;
            EXECUTE:  next_state = ALUWB;
            ADDIEXEC: next_state = ADDIWB;
            default:  next_state = FETCH;
        endcase
    end

    // Moore outputs: everything defaults low, each state raises its own set.
    always_comb begin
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        IorD     = 1'b0;
        PCSrc    = 1'b0;
        ALUSrcA  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcB  = 2'b00;
        alu_op   = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR, ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ADDIWB:   RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 1'b1;
                Branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder
    always_comb begin
        ALUControl = 3'b010;
        case (alu_op)
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns / 100ps
// tb_control_unit
// Self-checking bench for control_unit: a table of instruction sequences
// with hand-written expected outputs, randomized instructions checked against
// a per-instruction-class reference model, and hand sequences for reset and
// mid-instruction opcode changes.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite;
    logic       MemWrite, PCWrite, Branch, RegWrite;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;

    control_unit dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl)
    );

    // Output word: {MemtoReg,RegDst,IorD,PCSrc,ALUSrcA,IRWrite,MemWrite,
    //               PCWrite,Branch,RegWrite,ALUSrcB[1:0],ALUControl[2:0]}
    logic [14:0] outs;
    assign outs = {MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite,
                   PCWrite, Branch, RegWrite, ALUSrcB, ALUControl};

    int unsigned checks = 0;
    int unsigned errors = 0;

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    // Build an output word from named fields.
    function automatic logic [14:0] ow(input logic mtr, input logic rd, input logic iord,
                                       input logic pcs, input logic asa, input logic irw,
                                       input logic mw, input logic pcw, input logic br,
                                       input logic rw, input logic [1:0] bsel,
                                       input logic [2:0] ctl);
        return {mtr, rd, iord, pcs, asa, irw, mw, pcw, br, rw, bsel, ctl};
    endfunction

    // Expected phase outputs written straight from the state output tables.
    logic [14:0] E_FETCH, E_DECODE, E_ADR, E_MRD, E_MWR, E_MWB, E_AWB, E_IWB, E_BR;
    function automatic logic [14:0] e_exec(input logic [2:0] ctl);
        return ow(0,0,0,0,1,0,0,0,0,0,2'b00,ctl);
    endfunction

    task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic [5:0]      fn;
        int unsigned     len;
        logic [5:0][14:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned len, input logic [14:0] e0, input logic [14:0] e1,
                           input logic [14:0] e2, input logic [14:0] e3, input logic [14:0] e4);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.len = len;
        v.exp = '0;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        tbl.push_back(v);
    endtask

    // Reference model: outputs per cycle derived from the instruction class.
    function automatic logic [2:0] alu_fn(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    logic [14:0] model_q[$];
    task automatic model(input logic [5:0] op, input logic [5:0] fn);
        model_q.delete();
        model_q.push_back(E_FETCH);
        model_q.push_back(E_DECODE);
        if (op == 6'b100011) begin
            model_q.push_back(E_ADR); model_q.push_back(E_MRD); model_q.push_back(E_MWB);
        end else if (op == 6'b101011) begin
            model_q.push_back(E_ADR); model_q.push_back(E_MWR);
        end else if (op == 6'b000000) begin
            model_q.push_back(e_exec(alu_fn(fn))); model_q.push_back(E_AWB);
        end else if (op == 6'b000100) begin
            model_q.push_back(E_BR);
        end else if (op == 6'b001000) begin
            model_q.push_back(E_ADR); model_q.push_back(E_IWB);
        end
    endtask

    // Entered on a falling edge with the DUT in FETCH; returns on the falling
    // edge where the DUT is back in FETCH.
    task automatic run_seq(input string nm, input logic [5:0] op, input logic [5:0] fn);
        Opcode = op;
        Funct  = fn;
        foreach (model_q[k]) begin
            #1;
            check($sformatf("%s[%0d]", nm, k), outs, model_q[k]);
            @(negedge clk);
        end
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;

    initial begin
        E_FETCH  = ow(0,0,0,0,0,1,0,1,0,0,2'b01,3'b010);
        E_DECODE = ow(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010);
        E_ADR    = ow(0,0,0,0,1,0,0,0,0,0,2'b10,3'b010);
        E_MRD    = ow(0,0,1,0,0,0,0,0,0,0,2'b00,3'b010);
        E_MWR    = ow(0,0,1,0,0,0,1,0,0,0,2'b00,3'b010);
        E_MWB    = ow(1,0,0,0,0,0,0,0,0,1,2'b00,3'b010);
        E_AWB    = ow(0,1,0,0,0,0,0,0,0,1,2'b00,3'b010);
        E_IWB    = ow(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010);
        E_BR     = ow(0,0,0,1,1,0,0,0,1,0,2'b00,3'b110);

        add_row("lw",   LW,   6'h00,     5, E_FETCH, E_DECODE, E_ADR, E_MRD, E_MWB);
        add_row("sw",   SW,   6'h00,     4, E_FETCH, E_DECODE, E_ADR, E_MWR, '0);
        add_row("beq",  BEQ,  6'h00,     3, E_FETCH, E_DECODE, E_BR, '0, '0);
        add_row("addi", ADDI, 6'h00,     4, E_FETCH, E_DECODE, E_ADR, E_IWB, '0);
        add_row("bad",  BAD,  6'h00,     2, E_FETCH, E_DECODE, '0, '0, '0);
        add_row("add",  RT,   6'b100000, 4, E_FETCH, E_DECODE, e_exec(3'b010), E_AWB, '0);
        add_row("sub",  RT,   6'b100010, 4, E_FETCH, E_DECODE, e_exec(3'b110), E_AWB, '0);
        add_row("and",  RT,   6'b100100, 4, E_FETCH, E_DECODE, e_exec(3'b000), E_AWB, '0);
        add_row("or",   RT,   6'b100101, 4, E_FETCH, E_DECODE, e_exec(3'b001), E_AWB, '0);
        add_row("slt",  RT,   6'b101010, 4, E_FETCH, E_DECODE, e_exec(3'b111), E_AWB, '0);
        add_row("rfn0", RT,   6'b000000, 4, E_FETCH, E_DECODE, e_exec(3'b010), E_AWB, '0);
        add_row("rfnx", RT,   6'b111000, 4, E_FETCH, E_DECODE, e_exec(3'b010), E_AWB, '0);

        // Power-on reset: FETCH outputs while rst low, regardless of inputs.
        rst = 1'b0; Opcode = 6'b101011; Funct = 6'b101010;
        #1 check("reset_t1", outs, E_FETCH);
        @(negedge clk);
        Opcode = RT; Funct = 6'h00;
        #1 check("reset_t5", outs, E_FETCH);
        rst = 1'b1;
        // First transition at the rising edge after release: R-type, funct 0.
        model(RT, 6'h00);
        void'(model_q.pop_front());
        @(negedge clk);
        foreach (model_q[k]) begin
            #1 check($sformatf("post_reset[%0d]", k), outs, model_q[k]);
            @(negedge clk);
        end

        // Table-driven sequences.
        foreach (tbl[i]) begin
            model_q.delete();
            for (int unsigned k = 0; k < tbl[i].len; k++) model_q.push_back(tbl[i].exp[k]);
            run_seq(tbl[i].name, tbl[i].op, tbl[i].fn);
        end

        // Reset asserted mid-lw in MEMREAD; opcode junk while in reset.
        Opcode = LW; Funct = 6'h00;
        #1 check("mid_fetch", outs, E_FETCH);
        @(negedge clk); #1 check("mid_decode", outs, E_DECODE);
        @(negedge clk); #1 check("mid_memadr", outs, E_ADR);
        @(negedge clk); #1 check("mid_memread", outs, E_MRD);
        rst = 1'b0;
        #0.5 check("mid_async", outs, E_FETCH);
        Opcode = BAD;
        @(negedge clk); #1 check("mid_held", outs, E_FETCH);
        rst = 1'b1;
        @(negedge clk); #1 check("mid_rel_decode", outs, E_DECODE);
        @(negedge clk);

        // Opcode changes to addi while in MEMADR: falls back to FETCH.
        Opcode = LW;
        #1 check("chg_fetch", outs, E_FETCH);
        @(negedge clk); #1 check("chg_decode", outs, E_DECODE);
        @(negedge clk); Opcode = ADDI;
        #1 check("chg_memadr", outs, E_ADR);
        @(negedge clk); #1 check("chg_back_fetch", outs, E_FETCH);
        @(negedge clk); #1 check("chg_decode2", outs, E_DECODE);
        Opcode = BAD;
        @(negedge clk);

        // Randomized instructions against the model.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            case ($urandom_range(0, 5))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = BEQ;
                4: op = ADDI;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            model(op, fn);
            run_seq($sformatf("rnd%0d_op%b_fn%b", n, op, fn), op, fn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
